hashout_reader: RTL and testbench
=================================

# hashout_reader

Drains the hashout FIFO filled by the matrix multiplier control path, assembles `WORDS_PER_HASH` consecutive words into one heavyhash result, and compares it against the mining target. Each result is presented on a valid/ready output port with a sequence index. The block sits between the hashout FIFO read side and the nonce-reporting logic of the oBTC miner.

## Interface
- `WORD_W`, 64, width of one hashout FIFO word
- `WORDS_PER_HASH`, 4, FIFO words per hash; hash width `HASH_W = WORD_W*WORDS_PER_HASH`; legal range 2..16

- `clk`  in  1  global clock
- `rst_n`  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset
- `hashout_empty`  in  1  empty flag of the hashout FIFO
- `hashout_dout`  in  `WORD_W`  FIFO read data, valid the cycle after `hashout_re`
- `hashout_re`  out  1  FIFO read enable
- `target`  in  `HASH_W`  unsigned target, quasi-static
- `res_valid`  out  1  result available
- `res_ready`  in  1  downstream accepts result
- `res_hash`  out  `HASH_W`  assembled hash
- `res_meets_target`  out  1  `res_hash <= target`
- `res_index`  out  32  sequence number of this result

## Operation
- Reset values: `hashout_re`=0, `res_valid`=0, `res_hash`=0, `res_meets_target`=0, `res_index`=0. Internal state: word counters=0, `rd_pending`=0, state=READ.
- States:
  - READ: `hashout_re` is combinationally `!hashout_empty && issued < WORDS_PER_HASH`. Each asserted read increments `issued` and sets `rd_pending` for the next cycle. A pending read captures `hashout_dout` into slot `captured`; the first word goes to bits [WORD_W-1:0], later words go to successively higher slices. When `captured` reaches `WORDS_PER_HASH`, go to CMP.
  - CMP: one cycle. Register `res_meets_target` from an unsigned `assembled <= target` compare (full `HASH_W` width). Copy assembled to `res_hash`. Set `res_valid`=1 and go to OUT.
  - OUT: hold all `res_*` stable while `res_valid && !res_ready`. On `res_valid && res_ready`:
    - `res_valid`=0 next cycle
    - `res_index` += 1, wrapping 0xFFFFFFFF -> 0
    - clear `issued`/`captured`
    - go to READ
- `hashout_re` is never asserted in CMP or OUT. It is never asserted when `hashout_empty`=1. No read of the next hash overlaps an unaccepted result.
- Empty mid-hash: reads stall and partial words are retained. A read issued before empty rose is still captured.
- `target` is sampled only in CMP.
- Reset mid-operation (any state) asynchronously discards partial words and any unaccepted result. No FIFO words are re-read.

## Timing
- FIFO read latency is 1 cycle. With the FIFO continuously non-empty, the first `hashout_re` comes at cycle t0, words are issued t0..t0+W-1, the last capture lands at t0+W, CMP runs at t0+W+1, and `res_valid` goes high at t0+W+2. W = `WORDS_PER_HASH`.
- Best-case throughput is one hash per W+3 cycles with `res_ready` tied high. The handshake cycle is followed by READ issuing again on the next cycle.
- `res_ready` high in the same cycle `res_valid` rises completes the handshake in that cycle.
- All outputs are registered except `hashout_re`, which is combinational from state, counter and `hashout_empty`.

## Test plan
- Reset, then FIFO preloaded with words 0x1,0x2,0x3,0x4 (W=4), `target`=all ones, `res_ready`=1 -> exactly 4 `hashout_re` pulses. `res_hash`=0x0000000000000004_0000000000000003_0000000000000002_0000000000000001, `res_meets_target`=1, `res_index`=0, and `res_valid` high 6 cycles after the first re.
- Same hash with `target`=res_hash-1 -> `res_meets_target`=0. With `target`=res_hash exactly -> 1.
- `hashout_empty` toggles every other cycle during a hash -> `hashout_re` never asserted while empty, and the assembled value equals the in-order words.
- `res_ready`=0 for 10 cycles with the FIFO non-empty -> outputs stable, zero reads issued. Then `res_ready`=1 -> one handshake, `res_index`=1 on the next result.
- Force the index to 0xFFFFFFFF, accept one result -> next `res_index`=0.
- Assert `rst_n`=0 after 2 of 4 words are captured, release it, then push 4 fresh words -> the result contains only the fresh words and `res_index`=0.

Source files
------------

// File: rtl/hashout_reader.sv
// ---------------------------------------------------------------------------
// hashout_reader
//   Drains the hashout FIFO, assembles WORDS_PER_HASH consecutive words into a
//   single heavyhash result (first word in the least-significant slice),
//   compares it against the mining target and offers it on a valid/ready port
//   with a 32-bit sequence index.
//
// Ports
//   clk              in   global clock
//   rst_n            in   asynchronous active-low reset
//   hashout_empty    in   FIFO empty flag
//   hashout_dout     in   FIFO read data, valid the cycle after hashout_re
//   hashout_re       out  FIFO read enable (combinational)
//   target           in   unsigned mining target, sampled in CMP only
//   res_valid        out  result available
//   res_ready        in   downstream accepts result
//   res_hash         out  assembled hash
//   res_meets_target out  res_hash <= target
//   res_index        out  sequence number of this result
//
// States
//   S_READ | issue FIFO reads and capture returning words
//   S_CMP  | one cycle: compare against target, load result registers
//   S_OUT  | hold result until res_ready, then bump index and restart
// ---------------------------------------------------------------------------
module hashout_reader #(
    parameter int WORD_W         = 64,
    parameter int WORDS_PER_HASH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               hashout_empty,
    input  logic [WORD_W-1:0]                  hashout_dout,
    output logic                               hashout_re,
    input  logic [WORD_W*WORDS_PER_HASH-1:0]   target,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [WORD_W*WORDS_PER_HASH-1:0]   res_hash,
    output logic                               res_meets_target,
    output logic [31:0]                        res_index
);

    localparam int HASH_W = WORD_W * WORDS_PER_HASH;
    localparam int CNT_W  = $clog2(WORDS_PER_HASH + 1);

    localparam logic [CNT_W-1:0] C_WORDS = CNT_W'(WORDS_PER_HASH);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(WORDS_PER_HASH - 1);

    typedef enum logic [1:0] {
        S_READ = 2'd0,
        S_CMP  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_issued;
    logic [CNT_W-1:0]    r_captured;
    logic                r_rd_pending;
    logic [HASH_W-1:0]   r_assembled;
    logic                r_res_valid;
    logic [HASH_W-1:0]   r_res_hash;
    logic                r_res_meets;
    logic [31:0]         r_res_index;
    logic                w_accept;

    assign res_valid        = r_res_valid;
    assign res_hash         = r_res_hash;
    assign res_meets_target = r_res_meets;
    assign res_index        = r_res_index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_READ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        hashout_re  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_READ: begin
                hashout_re = !hashout_empty && (r_issued < C_WORDS);
                // The final word lands this cycle; the compare runs next.
                if (r_rd_pending && (r_captured == C_LAST)) begin
                    w_state_nxt = S_CMP;
                end
            end
            S_CMP: begin
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (r_res_valid && res_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            default: begin
                w_state_nxt = S_READ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued     <= '0;
            r_captured   <= '0;
            r_rd_pending <= 1'b0;
            r_assembled  <= '0;
            r_res_valid  <= 1'b0;
            r_res_hash   <= '0;
            r_res_meets  <= 1'b0;
            r_res_index  <= '0;
        end else begin
            r_rd_pending <= hashout_re;
            if (hashout_re) begin
                r_issued <= r_issued + 1'b1;
            end
            // A read issued before empty rose still returns data here.
            if (r_rd_pending) begin
                for (int k = 0; k < WORDS_PER_HASH; k++) begin
                    if (r_captured == CNT_W'(k)) begin
                        r_assembled[k*WORD_W +: WORD_W] <= hashout_dout;
                    end
                end
                r_captured <= r_captured + 1'b1;
            end
            if (r_state == S_CMP) begin
                r_res_meets <= (r_assembled <= target);
                r_res_hash  <= r_assembled;
                r_res_valid <= 1'b1;
            end
            if (w_accept) begin
                r_res_valid <= 1'b0;
                r_res_index <= r_res_index + 32'd1;
                r_issued    <= '0;
                r_captured  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hashout_reader.sv
module tb_hashout_reader;

    localparam int WORD_W = 64;
    localparam int WPH    = 4;
    localparam int HW     = WORD_W * WPH;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              hashout_empty;
    logic [WORD_W-1:0] hashout_dout = '0;
    logic              hashout_re;
    logic [HW-1:0]     target = '1;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [HW-1:0]     res_hash;
    logic              res_meets_target;
    logic [31:0]       res_index;

    hashout_reader #(.WORD_W(WORD_W), .WORDS_PER_HASH(WPH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .hashout_empty    (hashout_empty),
        .hashout_dout     (hashout_dout),
        .hashout_re       (hashout_re),
        .target           (target),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_hash         (res_hash),
        .res_meets_target (res_meets_target),
        .res_index        (res_index)
    );

    always #5 clk = ~clk;

    // FIFO model: one-cycle read latency, empty flag refreshed on negedge.
    logic [WORD_W-1:0] fifo_q[$];
    logic              q_empty = 1'b1;
    logic              gate_empty = 1'b0;
    logic              toggle_en = 1'b0;
    assign hashout_empty = q_empty | gate_empty;

    int cyc = 0;
    int re_count = 0;
    int re_bad = 0;
    int first_re_cyc = -1;
    int first_valid_cyc = -1;

    logic [HW-1:0] rh_q[$];
    logic          rm_q[$];
    logic [31:0]   ri_q[$];

    int passes = 0;
    int total  = 0;

    always @(posedge clk) begin
        cyc++;
        if (hashout_re) begin
            re_count++;
            if (hashout_empty) re_bad++;
            if (first_re_cyc < 0) first_re_cyc = cyc;
            if (fifo_q.size() > 0) hashout_dout <= fifo_q.pop_front();
            else re_bad++;
        end
        if (res_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (res_valid && res_ready) begin
            rh_q.push_back(res_hash);
            rm_q.push_back(res_meets_target);
            ri_q.push_back(res_index);
        end
    end

    always @(negedge clk) begin
        q_empty    = (fifo_q.size() == 0);
        gate_empty = toggle_en ? ~gate_empty : 1'b0;
    end

    task automatic check(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push4(input logic [WORD_W-1:0] a, b, c, d);
        fifo_q.push_back(a);
        fifo_q.push_back(b);
        fifo_q.push_back(c);
        fifo_q.push_back(d);
    endtask

    task automatic get_result(input string tag, output logic [HW-1:0] h,
                              output logic m, output logic [31:0] i);
        int n = 0;
        while (rh_q.size() == 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_arrived"}, HW'(rh_q.size() != 0), HW'(1));
        if (rh_q.size() != 0) begin
            h = rh_q.pop_front();
            m = rm_q.pop_front();
            i = ri_q.pop_front();
        end else begin
            h = 'x;
            m = 1'bx;
            i = 'x;
        end
    endtask

    logic [HW-1:0] h;
    logic          m;
    logic [31:0]   idx;
    int            rc;
    int            n;

    localparam logic [HW-1:0] H1 = {64'h4, 64'h3, 64'h2, 64'h1};
    localparam logic [HW-1:0] H4 = {64'h14, 64'h13, 64'h12, 64'h11};
    localparam logic [HW-1:0] H5 = {64'h24, 64'h23, 64'h22, 64'h21};
    localparam logic [HW-1:0] H6 = {64'h34, 64'h33, 64'h32, 64'h31};
    localparam logic [HW-1:0] HF = {64'h44, 64'h43, 64'h42, 64'h41};
    localparam logic [HW-1:0] HG = {64'h54, 64'h53, 64'h52, 64'h51};
    localparam logic [HW-1:0] H7 = {64'h74, 64'h73, 64'h72, 64'h71};

    initial begin
        repeat (3) @(negedge clk);
        check("rst_re",    HW'(hashout_re),       HW'(0));
        check("rst_valid", HW'(res_valid),        HW'(0));
        check("rst_hash",  res_hash,              HW'(0));
        check("rst_meets", HW'(res_meets_target), HW'(0));
        check("rst_index", HW'(res_index),        HW'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic hash, target all ones, ready tied high.
        push4(64'h1, 64'h2, 64'h3, 64'h4);
        get_result("t1", h, m, idx);
        check("t1_hash",  h,       H1);
        check("t1_meets", HW'(m),  HW'(1));
        check("t1_index", HW'(idx), HW'(0));
        check("t1_latency", HW'(first_valid_cyc - first_re_cyc), HW'(6));
        repeat (4) @(negedge clk);
        check("t1_re_count", HW'(re_count), HW'(4));

        // Target boundary: one below the hash, then exactly equal.
        target = H1 - 1'b1;
        push4(64'h1, 64'h2, 64'h3, 64'h4);
        get_result("t2", h, m, idx);
        check("t2_hash",  h,        H1);
        check("t2_meets", HW'(m),   HW'(0));
        check("t2_index", HW'(idx), HW'(1));
        target = H1;
        push4(64'h1, 64'h2, 64'h3, 64'h4);
        get_result("t3", h, m, idx);
        check("t3_meets", HW'(m),   HW'(1));
        check("t3_index", HW'(idx), HW'(2));
        target = '1;

        // Empty flag toggling every cycle during a hash.
        toggle_en = 1'b1;
        push4(64'h11, 64'h12, 64'h13, 64'h14);
        get_result("t4", h, m, idx);
        toggle_en = 1'b0;
        check("t4_hash",  h,        H4);
        check("t4_index", HW'(idx), HW'(3));
        check("t4_re_when_empty", HW'(re_bad), HW'(0));

        // Back-pressure with further words waiting in the FIFO.
        res_ready = 1'b0;
        push4(64'h21, 64'h22, 64'h23, 64'h24);
        push4(64'h31, 64'h32, 64'h33, 64'h34);
        n = 0;
        while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t5_valid_rise", HW'(res_valid), HW'(1));
        rc = re_count;
        repeat (10) @(negedge clk);
        check("t5_hold_valid", HW'(res_valid), HW'(1));
        check("t5_hold_hash",  res_hash,       H5);
        check("t5_hold_index", HW'(res_index), HW'(4));
        check("t5_no_reads",   HW'(re_count),  HW'(rc));
        res_ready = 1'b1;
        get_result("t5a", h, m, idx);
        check("t5a_hash",  h,        H5);
        check("t5a_index", HW'(idx), HW'(4));
        get_result("t5b", h, m, idx);
        check("t5b_hash",  h,        H6);
        check("t5b_index", HW'(idx), HW'(5));

        // Index wrap.
        repeat (3) @(negedge clk);
        force dut.r_res_index = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_res_index;
        push4(64'h41, 64'h42, 64'h43, 64'h44);
        get_result("t6a", h, m, idx);
        check("t6a_hash",  h,        HF);
        check("t6a_index", HW'(idx), HW'(32'hFFFF_FFFF));
        push4(64'h51, 64'h52, 64'h53, 64'h54);
        get_result("t6b", h, m, idx);
        check("t6b_hash",  h,        HG);
        check("t6b_index", HW'(idx), HW'(0));

        // Reset with a half-assembled hash.
        fifo_q.push_back(64'h61);
        fifo_q.push_back(64'h62);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t7_rst_index", HW'(res_index), HW'(0));
        check("t7_rst_valid", HW'(res_valid), HW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        push4(64'h71, 64'h72, 64'h73, 64'h74);
        get_result("t7", h, m, idx);
        check("t7_hash",  h,        H7);
        check("t7_index", HW'(idx), HW'(0));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
